sae_seq_core: RTL and testbench
===============================

# sae_seq_core

Sequential responder for the SAE request/response handshake: it accepts one request per `inputs_valid` pulse (public-key generation, encryption or decryption of a single byte) and returns one byte plus status flags. Modular multiplication is computed iteratively, one key bit per cycle. The block sits behind the per-party SAE interface driven by the Walt/Jesse benches and is a drop-in port-compatible responder.

## Interface
- `N`, 8'd227, prime modulus; all keys and ciphertext bytes lie in 0..N-1.
- `K`, 8'd89, generator constant; must satisfy 0 < K < N.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mode`  in  2  request type: 00 idle/clear, 01 keygen, 10 encrypt, 11 decrypt.
- `data_input`  in  8  plaintext byte (10) or ciphertext byte (11); ignored for 01.
- `key_input`  in  8  private key sk (01, 11) or public key pk (10).
- `inputs_valid`  in  1  request strobe, sampled on rising edge.
- `data_output`  out  8  result byte: pk, ciphertext or plaintext.
- `output_ready`  out  1  result valid; held until the next accepted request.
- `err_invalid_ptxt_char`  out  1  plaintext outside 0x20..0x7E.
- `err_invalid_seckey`  out  1  key out of range.
- `err_invalid_ctxt_char`  out  1  ciphertext byte >= N.

## Operation
- States: IDLE, MUL, FIN, DONE. Accepts requests only in IDLE or DONE; `inputs_valid` in MUL/FIN ignored, no effect.
- Accept at edge E0: capture `mode`, `data_input`, `key_input`; clear `output_ready`, all err flags, `data_output` to 0.
- mode 00 + `inputs_valid`: clear outputs only, go IDLE.
- Validation on captured values: keygen/decrypt sk must be 1..N-1, else `err_invalid_seckey`. Encrypt pk must be < N, else `err_invalid_seckey`. Encrypt ptxt must be 0x20..0x7E, else `err_invalid_ptxt_char`. Decrypt ctxt must be < N, else `err_invalid_ctxt_char`. Key error has priority; exactly one flag is raised. On error there is no computation, `data_output` = 0, and `output_ready` stays 0.
- Keygen: pk = (sk*K) mod N.
- Encrypt: c = (p + pk) mod N.
- Decrypt: recompute pk from sk, then p = (c - pk) mod N.
- Modmul (MUL, 8 cycles, sk bit 7 down to 0):
  - acc = 2*acc, minus N if >= N;
  - then if bit set, acc = acc+K, minus N if >= N.
  - 9-bit intermediates; acc is 8-bit and always < N.
- Add/sub mod N: 9-bit sum minus N if >= N; for subtraction add N on borrow.
- Results and flags are held in DONE until the next accepted request.

## Timing
- Reset values: `data_output`=0, `output_ready`=0, all err flags=0, state IDLE, acc=0.
- Encrypt and all validation errors: outputs registered at E1, visible one cycle after acceptance.
- Keygen and decrypt: MUL at E1..E8, result registered at E9 (FIN→DONE). Latency is 9 cycles.
- `rst_n` low mid-MUL: immediate return to reset values, operation discarded.
- `inputs_valid` in DONE on the same edge result would be held: new request accepted, old result cleared.

## Configuration
- `SAE_PK_CACHE_EN` defined: a register pair {sk, pk} is written on every completed modmul, with a valid bit cleared by reset.
  - Keygen/decrypt whose sk matches a valid cached sk skips MUL; result is registered at E1, latency 1.
  - Cache is not updated on error.
- Undefined: no cache; every keygen/decrypt takes 9 cycles.

## Test plan
- Keygen sk=1 -> after 9 cycles `data_output`=89, `output_ready`=1. sk=3 -> 40. sk=226 -> 138.
- Encrypt pk=89, ptxt 0x41 -> after 1 cycle `data_output`=0x9A. Decrypt sk=1, ctxt 0x9A -> 0x41 after 9 cycles.
- Errors, each with `output_ready`=0 and the flag high after 1 cycle:
  - keygen sk=0 -> `err_invalid_seckey`;
  - encrypt ptxt 0x10 -> `err_invalid_ptxt_char`;
  - decrypt ctxt 0xE5 -> `err_invalid_ctxt_char`;
  - encrypt pk=0xF0 with ptxt 0x10 -> only `err_invalid_seckey`.
- Wrap-around: encrypt pk=40, ptxt 'z' (122) -> 162. Encrypt pk=138, ptxt 0x7E (126) -> 37. Decrypt sk=226, ctxt 37 -> 126.
- `inputs_valid` pulse during MUL is ignored, result unchanged. `rst_n` low at cycle 4 of MUL -> all outputs 0. Next keygen sk=2 -> 178.
- With `SAE_PK_CACHE_EN`: keygen sk=3 (9 cycles), then decrypt sk=3, ctxt 162 -> 122 after 1 cycle.

Source files
------------

// File: rtl/sae_seq_core.sv
// SAE responder: keygen (sk*K mod N), encrypt (p+pk mod N) and decrypt (c-pk mod N) of one byte per request.
// Latency: encrypt and any validation error 1 cycle; keygen/decrypt 9 cycles (1 on a pk cache hit).
// Backpressure: none; requests are taken only in IDLE/DONE, and inputs_valid while busy is dropped.
//
// Ports: clk, rst_n (async, active low); mode/data_input/key_input/inputs_valid carry the request;
// data_output/output_ready carry the result, held until the next accepted request;
// err_invalid_{seckey,ptxt_char,ctxt_char} report a rejected request (exactly one is raised).
// Optional macro SAE_PK_CACHE_EN: remembers the last {sk, pk} pair so that a repeat sk skips the
// bit-serial multiply.
module sae_seq_core #(
    parameter logic [7:0] N = 8'd227,
    parameter logic [7:0] K = 8'd89
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic [7:0] data_input,
    input  logic [7:0] key_input,
    input  logic       inputs_valid,
    output logic [7:0] data_output,
    output logic       output_ready,
    output logic       err_invalid_ptxt_char,
    output logic       err_invalid_seckey,
    output logic       err_invalid_ctxt_char
);

    localparam logic [8:0] N9     = {1'b0, N};
    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_KG  = 2'b01;
    localparam logic [1:0] OP_ENC = 2'b10;
    localparam logic [1:0] OP_DEC = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_FIN, S_DONE} state_t;

    state_t     state;
    logic [1:0] op_r;
    logic [7:0] dat_r;
    logic [7:0] key_r;
    logic [7:0] acc;
    logic [2:0] bit_idx;
    logic       pend_key;
    logic       pend_ptxt;
    logic       pend_ctxt;

    // Request validation is evaluated on the request itself so the accept edge can already
    // choose between the multiply path and the single-cycle FIN path.
    logic uses_sk, key_bad, ptxt_bad, ctxt_bad, need_mul, cache_hit;
    logic [7:0] cache_pk;

    always_comb begin
        uses_sk  = (mode == OP_KG) || (mode == OP_DEC);
        key_bad  = uses_sk ? ((key_input == 8'd0) || (key_input >= N))
                           : ((mode == OP_ENC) && (key_input >= N));
        ptxt_bad = (mode == OP_ENC) && !key_bad &&
                   ((data_input < 8'h20) || (data_input > 8'h7E));
        ctxt_bad = (mode == OP_DEC) && !key_bad && (data_input >= N);
        need_mul = uses_sk && !key_bad && !ctxt_bad;
    end

    // One MSB-first double-and-add step. acc < N keeps every sum below 2N, so a single
    // conditional subtract reduces it; the 8-bit subtract wraps to the exact residue.
    logic [8:0] dbl, add;
    logic [7:0] dbl_red, add_red, mul_next;

    always_comb begin
        dbl      = {acc, 1'b0};
        dbl_red  = (dbl >= N9) ? (dbl[7:0] - N) : dbl[7:0];
        add      = {1'b0, dbl_red} + {1'b0, K};
        add_red  = (add >= N9) ? (add[7:0] - N) : add[7:0];
        mul_next = key_r[bit_idx] ? add_red : dbl_red;
    end

    // Final add/sub mod N; on borrow c + N - pk is already the true residue modulo 256.
    logic [8:0] enc_sum;
    logic [7:0] enc_res, dec_res;

    always_comb begin
        enc_sum = {1'b0, dat_r} + {1'b0, key_r};
        enc_res = (enc_sum >= N9) ? (enc_sum[7:0] - N) : enc_sum[7:0];
        dec_res = (dat_r >= acc) ? (dat_r - acc) : (dat_r + N - acc);
    end

`ifdef SAE_PK_CACHE_EN
    logic       cache_vld;
    logic [7:0] cache_sk;

    // Written only when a full multiply completes, so rejected or reset-aborted requests never land here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld <= 1'b0;
            cache_sk  <= 8'd0;
            cache_pk  <= 8'd0;
        end else if ((state == S_MUL) && (bit_idx == 3'd0)) begin
            cache_vld <= 1'b1;
            cache_sk  <= key_r;
            cache_pk  <= mul_next;
        end
    end

    assign cache_hit = cache_vld && (cache_sk == key_input);
`else
    assign cache_hit = 1'b0;
    assign cache_pk  = 8'd0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                 <= S_IDLE;
            op_r                  <= OP_CLR;
            dat_r                 <= 8'd0;
            key_r                 <= 8'd0;
            acc                   <= 8'd0;
            bit_idx               <= 3'd7;
            pend_key              <= 1'b0;
            pend_ptxt             <= 1'b0;
            pend_ctxt             <= 1'b0;
            data_output           <= 8'd0;
            output_ready          <= 1'b0;
            err_invalid_ptxt_char <= 1'b0;
            err_invalid_seckey    <= 1'b0;
            err_invalid_ctxt_char <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (inputs_valid) begin
                        op_r                  <= mode;
                        dat_r                 <= data_input;
                        key_r                 <= key_input;
                        bit_idx               <= 3'd7;
                        pend_key              <= key_bad;
                        pend_ptxt             <= ptxt_bad;
                        pend_ctxt             <= ctxt_bad;
                        data_output           <= 8'd0;
                        output_ready          <= 1'b0;
                        err_invalid_ptxt_char <= 1'b0;
                        err_invalid_seckey    <= 1'b0;
                        err_invalid_ctxt_char <= 1'b0;
                        // A cache hit preloads pk so FIN finishes exactly as after a multiply.
                        acc <= (need_mul && cache_hit) ? cache_pk : 8'd0;
                        if (mode == OP_CLR)
                            state <= S_IDLE;
                        else if (need_mul && !cache_hit)
                            state <= S_MUL;
                        else
                            state <= S_FIN;
                    end
                end
                S_MUL: begin
                    acc     <= mul_next;
                    bit_idx <= bit_idx - 3'd1;
                    if (bit_idx == 3'd0)
                        state <= S_FIN;
                end
                S_FIN: begin
                    state <= S_DONE;
                    if (pend_key || pend_ptxt || pend_ctxt) begin
                        err_invalid_seckey    <= pend_key;
                        err_invalid_ptxt_char <= pend_ptxt;
                        err_invalid_ctxt_char <= pend_ctxt;
                    end else begin
                        output_ready <= 1'b1;
                        case (op_r)
                            OP_KG:   data_output <= acc;
                            OP_ENC:  data_output <= enc_res;
                            OP_DEC:  data_output <= dec_res;
                            default: data_output <= 8'd0;
                        endcase
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sae_seq_core.sv
// Bench for sae_seq_core: directed literal cases plus randomized requests and resets.
// The reference model is arithmetic (sk*89 % 227 etc.) with a countdown to the result edge.
// Outputs are compared against the model on every falling clock edge.
module tb_sae_seq_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] mode = 2'd0;
    logic [7:0] data_input = 8'd0;
    logic [7:0] key_input = 8'd0;
    logic       inputs_valid = 1'b0;
    logic [7:0] data_output;
    logic       output_ready;
    logic       err_invalid_ptxt_char;
    logic       err_invalid_seckey;
    logic       err_invalid_ctxt_char;

    sae_seq_core dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .mode                  (mode),
        .data_input            (data_input),
        .key_input             (key_input),
        .inputs_valid          (inputs_valid),
        .data_output           (data_output),
        .output_ready          (output_ready),
        .err_invalid_ptxt_char (err_invalid_ptxt_char),
        .err_invalid_seckey    (err_invalid_seckey),
        .err_invalid_ctxt_char (err_invalid_ctxt_char)
    );

    always #5 clk = ~clk;

`ifdef SAE_PK_CACHE_EN
    localparam int DEC3_LAT = 1;
`else
    localparam int DEC3_LAT = 9;
`endif

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_dout = 0, m_rdy = 0, m_ek = 0, m_ep = 0, m_ec = 0;
    int remaining = 0;
    int p_dout = 0, p_rdy = 0, p_ek = 0, p_ep = 0, p_ec = 0, p_lat = 1, p_wc = 0, p_sk = 0, p_pk = 0;
    int c_ok = 0, c_sk = 0, c_pk = 0;

    task automatic plan(input int m, input int d, input int k);
        int  pk;
        bit  hit;
        p_dout = 0; p_rdy = 0; p_ek = 0; p_ep = 0; p_ec = 0; p_wc = 0; p_lat = 1; p_sk = k;
        hit = 1'b0;
`ifdef SAE_PK_CACHE_EN
        hit = (c_ok != 0) && (c_sk == k);
`endif
        pk = (k * 89) % 227;
        p_pk = pk;
        if (m == 1 || m == 3) begin
            if (k == 0 || k >= 227) p_ek = 1;
            else if (m == 3 && d >= 227) p_ec = 1;
            else begin
                p_rdy  = 1;
                p_dout = (m == 1) ? pk : (d - pk + 227) % 227;
                p_lat  = hit ? 1 : 9;
                p_wc   = hit ? 0 : 1;
            end
        end else begin
            if (k >= 227) p_ek = 1;
            else if (d < 32 || d > 126) p_ep = 1;
            else begin
                p_rdy  = 1;
                p_dout = (d + k) % 227;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout = 0; m_rdy = 0; m_ek = 0; m_ep = 0; m_ec = 0;
            remaining = 0; c_ok = 0;
        end else if (remaining > 0) begin
            remaining--;
            if (remaining == 0) begin
                m_dout = p_dout; m_rdy = p_rdy; m_ek = p_ek; m_ep = p_ep; m_ec = p_ec;
                if (p_wc != 0) begin
                    c_ok = 1; c_sk = p_sk; c_pk = p_pk;
                end
            end
        end else if (inputs_valid) begin
            m_dout = 0; m_rdy = 0; m_ek = 0; m_ep = 0; m_ec = 0;
            if (mode != 2'd0) begin
                plan(int'(mode), int'(data_input), int'(key_input));
                remaining = p_lat;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_dout", {24'd0, data_output}, m_dout);
        chk("cyc_rdy", {31'd0, output_ready}, m_rdy);
        chk("cyc_flags", {29'd0, err_invalid_seckey, err_invalid_ptxt_char, err_invalid_ctxt_char},
            m_ek * 4 + m_ep * 2 + m_ec);
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [1:0] m, input logic [7:0] d, input logic [7:0] k);
        @(negedge clk); #1;
        mode = m; data_input = d; key_input = k; inputs_valid = 1'b1;
        @(negedge clk); #1;
        inputs_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic expect_out(input string nm, input int d, input int r, input int f);
        chk({nm, "_dout"}, {24'd0, data_output}, d);
        chk({nm, "_rdy"}, {31'd0, output_ready}, r);
        chk({nm, "_flags"}, {29'd0, err_invalid_seckey, err_invalid_ptxt_char, err_invalid_ctxt_char}, f);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        expect_out("reset", 0, 0, 0);
        rst_n = 1'b1;

        send(2'd1, 8'd0, 8'd1);    wait_cyc(9); expect_out("kg_sk1", 89, 1, 0);
        send(2'd1, 8'd0, 8'd3);    wait_cyc(8); expect_out("kg_sk3_busy", 0, 0, 0);
        wait_cyc(1);               expect_out("kg_sk3", 40, 1, 0);
        send(2'd3, 8'd162, 8'd3);  wait_cyc(DEC3_LAT); expect_out("dec_sk3", 122, 1, 0);
        send(2'd1, 8'd0, 8'd226);  wait_cyc(9); expect_out("kg_sk226", 138, 1, 0);
        send(2'd2, 8'h41, 8'd89);  wait_cyc(1); expect_out("enc_41", 8'h9A, 1, 0);
        send(2'd3, 8'h9A, 8'd1);   wait_cyc(9); expect_out("dec_9a", 8'h41, 1, 0);
        send(2'd1, 8'd0, 8'd0);    wait_cyc(1); expect_out("err_sk0", 0, 0, 4);
        send(2'd2, 8'h10, 8'd89);  wait_cyc(1); expect_out("err_ptxt", 0, 0, 2);
        send(2'd3, 8'hE5, 8'd1);   wait_cyc(1); expect_out("err_ctxt", 0, 0, 1);
        send(2'd2, 8'h10, 8'hF0);  wait_cyc(1); expect_out("err_prio", 0, 0, 4);
        send(2'd2, 8'd122, 8'd40); wait_cyc(1); expect_out("enc_wrap_z", 162, 1, 0);
        send(2'd2, 8'h7E, 8'd138); wait_cyc(1); expect_out("enc_wrap_7e", 37, 1, 0);
        send(2'd3, 8'd37, 8'd226); wait_cyc(9); expect_out("dec_wrap", 126, 1, 0);

        // request pulse while multiplying must be dropped
        send(2'd1, 8'd0, 8'd3);
        @(negedge clk); #1;
        mode = 2'd2; data_input = 8'h41; key_input = 8'd89; inputs_valid = 1'b1;
        @(negedge clk); #1;
        inputs_valid = 1'b0;
        wait_cyc(7);               expect_out("ignore_in_mul", 40, 1, 0);

        // accept in DONE clears the old result, then reset mid-multiply discards the operation
        send(2'd1, 8'd0, 8'd226);  expect_out("accept_clears", 0, 0, 0);
        wait_cyc(3);
        rst_n = 1'b0;
        #1;                        expect_out("rst_mid_mul", 0, 0, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        wait_cyc(10);              expect_out("discarded", 0, 0, 0);
        send(2'd1, 8'd0, 8'd2);    wait_cyc(9); expect_out("kg_sk2", 178, 1, 0);

        // randomized traffic, including requests while busy, re-accepts in DONE and resets
        for (int i = 0; i < 800; i++) begin
            @(negedge clk); #1;
            rst_n        = ($urandom_range(0, 149) != 0);
            inputs_valid = ($urandom_range(0, 2) == 0);
            mode         = 2'($urandom_range(0, 3));
            if (mode == 2'd0 && $urandom_range(0, 3) != 0)
                mode = 2'($urandom_range(1, 3));
            case ($urandom_range(0, 5))
                0:       key_input = 8'($urandom_range(0, 255));
                1:       key_input = 8'd3;
                2:       key_input = 8'd226;
                default: key_input = 8'($urandom_range(1, 226));
            endcase
            if (mode == 2'd2)
                data_input = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(32, 126));
            else
                data_input = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(0, 255))
                                                          : 8'($urandom_range(0, 226));
        end
        inputs_valid = 1'b0;
        rst_n        = 1'b1;
        wait_cyc(12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
